// File: rtl/dsm_pkg.sv
// Shared types and parameter derivations for the sample serializer.
package dsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEAD = 2'd1,
    ST_BYTE = 2'd2
  } state_t;

  function automatic int nbytes(input int sample_w);
    return sample_w / 8;
  endfunction

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dsm_sync_fifo.sv
// Single-clock sample FIFO with occupancy count; read data is the head entry.
module dsm_sync_fifo
  import dsm_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        rd_en,
  output logic [WIDTH-1:0]            rd_data,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic                        full,
  output logic                        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_rd   = rd_en && !empty;
  // a write into a full FIFO is legal when the head leaves in the same cycle
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dsm_sample_serializer.sv
// Buffers decimated samples and emits each as a strobed lead-in followed by
// its bytes MSB first, each byte held for a fixed number of clocks.
module dsm_sample_serializer
  import dsm_pkg::*;
#(
  parameter int SAMPLE_W    = 24,
  parameter int FIFO_DEPTH  = 4,
  parameter int LEAD_CYCLES = 32,
  parameter int BYTE_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [SAMPLE_W-1:0]               in_data,
  output logic                              in_ready,
  output logic [7:0]                        out_byte,
  output logic                              out_strobe,
  output logic                              out_busy,
  output logic [1:0]                        byte_idx,
  output logic [level_w(FIFO_DEPTH)-1:0]    fifo_level,
  output logic                              overflow,
  input  logic                              clr_overflow
);

  localparam int NBYTES = nbytes(SAMPLE_W);
  localparam int MAXC   = (LEAD_CYCLES > BYTE_CYCLES) ? LEAD_CYCLES : BYTE_CYCLES;
  localparam int CNT_W  = $clog2(MAXC) + 1;
  localparam logic [CNT_W-1:0] LEAD_LOAD = CNT_W'(LEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BYTE_LOAD = CNT_W'(BYTE_CYCLES - 1);
  localparam logic [1:0]       LAST_IDX  = 2'(NBYTES - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [SAMPLE_W-1:0] shreg;
  logic                ready_en;
  logic [SAMPLE_W-1:0] fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                frame_end;
  logic                pop;
  logic                push;
  logic                drop;

  assign frame_end = (state == ST_BYTE) && (cnt == '0) && (byte_idx == LAST_IDX);
  assign pop       = !fifo_empty && ((state == ST_IDLE) || frame_end);
  // ready depends only on registered state, so there is no input-to-output path
  assign in_ready  = ready_en && (!fifo_full || pop);
  assign push      = in_valid && in_ready;
  assign drop      = in_valid && !in_ready;

  dsm_sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      out_byte   <= 8'h00;
      out_strobe <= 1'b0;
      out_busy   <= 1'b0;
      byte_idx   <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            state      <= ST_LEAD;
            shreg      <= fifo_head;
            cnt        <= LEAD_LOAD;
            out_strobe <= 1'b1;
            out_busy   <= 1'b1;
            out_byte   <= 8'h00;
            byte_idx   <= 2'd0;
          end
        end
        ST_LEAD: begin
          if (cnt == '0) begin
            state      <= ST_BYTE;
            cnt        <= BYTE_LOAD;
            out_strobe <= 1'b0;
            out_byte   <= shreg[SAMPLE_W-1 -: 8];
            shreg      <= shreg << 8;
            byte_idx   <= 2'd0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_BYTE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (byte_idx != LAST_IDX) begin
            cnt      <= BYTE_LOAD;
            out_byte <= shreg[SAMPLE_W-1 -: 8];
            shreg    <= shreg << 8;
            byte_idx <= byte_idx + 2'd1;
          end else if (pop) begin
            // next frame starts with no idle gap
            state      <= ST_LEAD;
            shreg      <= fifo_head;
            cnt        <= LEAD_LOAD;
            out_strobe <= 1'b1;
            out_byte   <= 8'h00;
            byte_idx   <= 2'd0;
          end else begin
            state    <= ST_IDLE;
            out_busy <= 1'b0;
            out_byte <= 8'h00;
            byte_idx <= 2'd0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          out_strobe <= 1'b0;
          out_busy   <= 1'b0;
          out_byte   <= 8'h00;
          byte_idx   <= 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dsm_sample_serializer.sv
// Randomized bench for dsm_sample_serializer against a frame-position model.
module tb_dsm_sample_serializer;

  localparam int DEPTH = 4;
  localparam int LEAD  = 32;
  localparam int BYTEC = 16;
  localparam int NB    = 3;
  localparam int FRAME = LEAD + NB * BYTEC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [23:0] in_data = '0;
  logic        clr = 1'b0;
  logic        in_ready, out_strobe, out_busy, overflow;
  logic [7:0]  out_byte;
  logic [1:0]  byte_idx;
  logic [2:0]  fifo_level;

  logic        v2 = 1'b0;
  logic [15:0] d2 = '0;
  logic        clr2 = 1'b0;
  logic        ready2, strobe2, busy2, ovf2;
  logic [7:0]  byte2;
  logic [1:0]  idx2;
  logic [2:0]  level2;

  dsm_sample_serializer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_byte(out_byte), .out_strobe(out_strobe), .out_busy(out_busy), .byte_idx(byte_idx),
    .fifo_level(fifo_level), .overflow(overflow), .clr_overflow(clr)
  );

  dsm_sample_serializer #(.SAMPLE_W(16), .FIFO_DEPTH(4), .LEAD_CYCLES(1), .BYTE_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_data(d2), .in_ready(ready2),
    .out_byte(byte2), .out_strobe(strobe2), .out_busy(busy2), .byte_idx(idx2),
    .fifo_level(level2), .overflow(ovf2), .clr_overflow(clr2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // model: FIFO contents as a queue, frame progress as a position 0..FRAME-1 (-1 = idle)
  logic [23:0] mq[$];
  int          mpos = -1;
  logic [23:0] mcur = '0;
  bit          movf = 1'b0;
  bit          mrdy_en = 1'b0;
  bit          m_p, m_rdy, m_psh, m_drp;
  bit          rec_en = 1'b0;
  logic [23:0] sent[$];

  function automatic bit mpop();
    return (mq.size() > 0) && (mpos == -1 || mpos == FRAME - 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mpos = -1; mcur = '0; movf = 1'b0; mrdy_en = 1'b0;
    end else begin
      m_p   = mpop();
      m_rdy = mrdy_en && ((mq.size() < DEPTH) || m_p);
      m_psh = in_valid && m_rdy;
      m_drp = in_valid && !m_rdy;
      if (m_p) mcur = mq.pop_front();
      if (m_psh) mq.push_back(in_data);
      if (m_psh && rec_en) sent.push_back(in_data);
      if (m_p) mpos = 0;
      else if (mpos == FRAME - 1) mpos = -1;
      else if (mpos >= 0) mpos++;
      if (m_drp) movf = 1'b1;
      else if (clr) movf = 1'b0;
      mrdy_en = 1'b1;
    end
  end

  bit          chk_en = 1'b0;
  bit          dec_en = 1'b0;
  int          k;
  logic [7:0]  e_byte;
  int          e_idx;
  bit          pstrobe;
  logic [1:0]  pidx;
  logic [23:0] acc;
  int          nacc;
  logic [23:0] decoded[$];

  always @(negedge clk) begin
    if (chk_en) begin
      e_byte = 8'h00; e_idx = 0;
      if (mpos >= LEAD) begin
        k = (mpos - LEAD) / BYTEC;
        e_byte = 8'((mcur >> (8 * (NB - 1 - k))) & 24'hFF);
        e_idx = k;
      end
      chk("cmp_in_ready", in_ready, mrdy_en && ((mq.size() < DEPTH) || mpop()));
      chk("cmp_out_busy", out_busy, mpos >= 0);
      chk("cmp_out_strobe", out_strobe, (mpos >= 0) && (mpos < LEAD));
      chk("cmp_out_byte", out_byte, e_byte);
      chk("cmp_byte_idx", byte_idx, e_idx);
      chk("cmp_fifo_level", fifo_level, mq.size());
      chk("cmp_overflow", overflow, movf);
    end
    if (dec_en) begin
      if (out_busy && !out_strobe && (pstrobe || byte_idx != pidx)) begin
        acc = {acc[15:0], out_byte};
        nacc++;
        if (nacc == NB) begin decoded.push_back(acc); nacc = 0; end
      end
      pstrobe = out_strobe; pidx = byte_idx;
    end else begin
      pstrobe = 1'b0; pidx = 2'd0; nacc = 0; acc = '0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int i;
    for (i = 0; i < maxc; i++) begin
      if (!out_busy && fifo_level == 0) break;
      step();
    end
    chk(name, i < maxc, 1);
  endtask

  int t, cs, cb, c12, c34, c56, f_s, f12, f34, f56, f_b, l_b;
  bit seen;

  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", out_busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_byte", out_byte, 0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    // short frame on the narrow instance: 0x8001, 1 lead + 2 single-cycle bytes
    v2 = 1'b1; d2 = 16'h8001; step(); v2 = 1'b0;
    cb = 0;
    step(); cb += busy2;
    chk("n_strobe", strobe2, 1); chk("n_lead_byte", byte2, 8'h00);
    step(); cb += busy2;
    chk("n_b0_strobe", strobe2, 0); chk("n_b0", byte2, 8'h80); chk("n_b0_idx", idx2, 0);
    step(); cb += busy2;
    chk("n_b1", byte2, 8'h01); chk("n_b1_idx", idx2, 1);
    step(); cb += busy2;
    chk("n_idle_busy", busy2, 0); chk("n_idle_byte", byte2, 8'h00);
    chk("n_frame_len", cb, 3);

    // single default frame 0x123456
    in_valid = 1'b1; in_data = 24'h123456; step(); in_valid = 1'b0;
    cs = 0; cb = 0; c12 = 0; c34 = 0; c56 = 0; f_s = -1; f12 = -1; f34 = -1; f56 = -1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (out_strobe) begin cs++; if (f_s < 0) f_s = i; end
      if (out_busy) cb++;
      if (out_busy && !out_strobe) begin
        if (out_byte == 8'h12) begin c12++; if (f12 < 0) f12 = i; end
        if (out_byte == 8'h34) begin c34++; if (f34 < 0) f34 = i; end
        if (out_byte == 8'h56) begin c56++; if (f56 < 0) f56 = i; end
      end
    end
    chk("s_strobe_cycles", cs, 32); chk("s_busy_cycles", cb, 80);
    chk("s_cnt12", c12, 16); chk("s_cnt34", c34, 16); chk("s_cnt56", c56, 16);
    chk("s_first_strobe", f_s, 0); chk("s_first12", f12, 32);
    chk("s_first34", f34, 48); chk("s_first56", f56, 64);
    chk("s_end_idle", out_busy, 0);

    // five consecutive pushes: all accepted, five frames back to back
    cb = 0; cs = 0; f_b = -1; l_b = -1; t = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 24'hA00000 + 24'(i); step();
      if (out_busy) begin cb++; cs += out_strobe; if (f_b < 0) f_b = t; l_b = t; end
      t++;
    end
    in_valid = 1'b0;
    chk("b2b_level", fifo_level, 4); chk("b2b_no_ovf", overflow, 0);
    for (int i = 0; i < 420; i++) begin
      step();
      if (out_busy) begin cb++; cs += out_strobe; if (f_b < 0) f_b = t; l_b = t; end
      t++;
    end
    chk("b2b_busy", cb, 400); chk("b2b_span", l_b - f_b + 1, 400);
    chk("b2b_strobes", cs, 160); chk("b2b_first", f_b, 1);

    // six pushes from idle: sixth dropped, overflow sticky, clear, set-wins
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 24'hB00000 + 24'(i); step();
    end
    in_valid = 1'b0;
    chk("ovf_set", overflow, 1); chk("ovf_level", fifo_level, 4);
    clr = 1'b1; step(); clr = 1'b0;
    chk("ovf_clr", overflow, 0);
    in_valid = 1'b1; in_data = 24'hBEEF00; clr = 1'b1; step(); in_valid = 1'b0; clr = 1'b0;
    chk("ovf_set_wins", overflow, 1); chk("ovf_level2", fifo_level, 4);
    clr = 1'b1; step(); clr = 1'b0;
    chk("ovf_clr2", overflow, 0);
    wait_idle(600, "drain1");

    // reset during byte 1 of a frame, with samples still queued
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 24'hC11111 * 24'(i + 1); step();
    end
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (out_busy && byte_idx == 2'd1) seen = 1'b1; else step();
    end
    chk("rst_reach_byte1", seen, 1);
    #3 rst = 1'b1; #1;
    chk("arst_busy", out_busy, 0); chk("arst_strobe", out_strobe, 0);
    chk("arst_byte", out_byte, 0); chk("arst_idx", byte_idx, 0);
    chk("arst_level", fifo_level, 0); chk("arst_ready", in_ready, 0);
    chk("arst_ovf", overflow, 0);
    step(); step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin step(); if (out_busy) seen = 1'b1; end
    chk("arst_no_resume", seen, 0); chk("arst_empty", fifo_level, 0);
    chk("arst_ready_back", in_ready, 1);

    // random heavy traffic with overflow and random clears
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 24'($urandom());
      clr      = ($urandom_range(0, 15) == 0);
      step();
    end
    in_valid = 1'b0; clr = 1'b0;
    wait_idle(600, "drain2");

    // random stream below throughput: decoded bytes reproduce the samples
    clr = 1'b1; step(); clr = 1'b0;
    rec_en = 1'b1; dec_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 24'($urandom()); step(); in_valid = 1'b0;
      repeat ($urandom_range(81, 110) - 1) step();
    end
    wait_idle(200, "drain3");
    step();
    rec_en = 1'b0; dec_en = 1'b0;
    chk("stream_count", decoded.size(), sent.size());
    chk("stream_sent8", sent.size(), 8);
    for (int i = 0; i < sent.size() && i < decoded.size(); i++)
      chk("stream_sample", decoded[i], sent[i]);
    chk("stream_no_ovf", overflow, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
